ami_tx_scheduler: RTL

//  Shares the single bipolar 3-level (AMI) line encoder between two word-wide requesters.

---
 rtl/ami_pkg.sv | 25 ++
 rtl/ami_baud_div.sv | 36 +++
 rtl/ami_tx_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/ami_pkg.sv
// ---------------------------------------------------------------------------
// ami_pkg
//  Shared definitions for the AMI line transmit path: the frame FSM state
//  encoding, the preamble start bit and a small helper used to size the
//  per-state bit counter. Imported by the scheduler and the line top level.
// ---------------------------------------------------------------------------
package ami_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } ami_state_e;

  // First preamble bit; the preamble then alternates from this value.
  localparam logic PRE_START_BIT = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ami_baud_div.sv
// ---------------------------------------------------------------------------
// ami_baud_div
//  Free-running divider that produces one TICK cycle every DIV clocks.
//  The count starts at 0 out of reset, so the first TICK arrives DIV-1
//  cycles after reset release.
// Ports
//  CLK         in   system clock
//  CPU_RESETN  in   asynchronous active-low reset
//  TICK        out  high for the single cycle in which the count is DIV-1
// ---------------------------------------------------------------------------
module ami_baud_div #(
  parameter int DIV = 4
) (
  input  logic CLK,
  input  logic CPU_RESETN,
  output logic TICK
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/ami_tx_scheduler.sv
// ---------------------------------------------------------------------------
// ami_tx_scheduler
//  Shares one AMI line encoder between two word-wide requesters. Each frame
//  is granted round-robin, then sent as preamble (1,0,1,0...), payload LSB
//  first and a gap of zeros. One line bit is produced per baud tick; the
//  line idles at 0 between frames while the strobe keeps running.
// Ports
//  CLK, CPU_RESETN          clock, asynchronous active-low reset
//  REQ0_VALID/DATA/READY    requester 0 handshake (READY = 1-cycle accept)
//  REQ1_VALID/DATA/READY    requester 1 handshake
//  LINE_BIT                 bit presented to the encoder SIGNAL input
//  LINE_STB                 1-cycle pulse, LINE_BIT is new this cycle
//  LINE_ACTIVE              high while a frame occupies the line
//  GRANT_ID                 requester owning the current/last frame
//  FRAME_DONE               1-cycle pulse at the tick ending a frame
// ---------------------------------------------------------------------------
module ami_tx_scheduler
  import ami_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DIV      = 4,
  parameter int PRE_BITS = 4,
  parameter int GAP_BITS = 2
) (
  input  logic              CLK,
  input  logic              CPU_RESETN,
  input  logic              REQ0_VALID,
  input  logic [DATA_W-1:0] REQ0_DATA,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [DATA_W-1:0] REQ1_DATA,
  output logic              REQ1_READY,
  output logic              LINE_BIT,
  output logic              LINE_STB,
  output logic              LINE_ACTIVE,
  output logic              GRANT_ID,
  output logic              FRAME_DONE
);

  localparam int CW = $clog2(max3(DATA_W, PRE_BITS, GAP_BITS) + 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_BITS - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_BITS > 0) ? (GAP_BITS - 1) : 0);

  logic tick;

  ami_baud_div #(.DIV(DIV)) u_baud (
    .CLK       (CLK),
    .CPU_RESETN(CPU_RESETN),
    .TICK      (tick)
  );

  ami_state_e        state, state_nxt;
  logic [CW-1:0]     bit_cnt, bit_cnt_nxt, bit_cnt_inc;
  logic [DATA_W-1:0] shift_reg, shift_nxt;
  logic              line_bit_nxt;
  logic              grant_nxt;
  logic              rr_ptr, rr_nxt;
  logic              ptr_now;
  logic              pick;
  logic              frame_end;
  logic              start_ok;
  logic              ready0, ready1;

  assign bit_cnt_inc = bit_cnt + 1'b1;

  // State, payload shift register, line outputs and arbitration pointer.
  // LINE_STB simply follows the tick one cycle later, so it runs in every
  // state with a period of exactly DIV clocks.
  always_ff @(posedge CLK or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      LINE_BIT  <= 1'b0;
      LINE_STB  <= 1'b0;
      GRANT_ID  <= 1'b0;
      rr_ptr    <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_reg <= shift_nxt;
      LINE_BIT  <= line_bit_nxt;
      LINE_STB  <= tick;
      GRANT_ID  <= grant_nxt;
      rr_ptr    <= rr_nxt;
    end
  end

  // Next-state logic. Everything moves on a tick only. bit_cnt holds the
  // index of the bit currently on the line within the current state. A
  // frame that ends on this tick falls through to the grant logic so a
  // pending request starts back-to-back without an idle bit; in that case
  // the pointer used is the one the finished frame is about to leave.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shift_nxt    = shift_reg;
    line_bit_nxt = LINE_BIT;
    grant_nxt    = GRANT_ID;
    rr_nxt       = rr_ptr;
    frame_end    = 1'b0;
    start_ok     = 1'b0;
    ready0       = 1'b0;
    ready1       = 1'b0;
    ptr_now      = rr_ptr;
    pick         = 1'b0;

    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          line_bit_nxt = 1'b0;
          start_ok     = 1'b1;
        end
        ST_PRE: begin
          if (bit_cnt == PRE_LAST) begin
            state_nxt    = ST_DATA;
            bit_cnt_nxt  = '0;
            line_bit_nxt = shift_reg[0];
            shift_nxt    = shift_reg >> 1;
          end else begin
            bit_cnt_nxt  = bit_cnt_inc;
            line_bit_nxt = PRE_START_BIT ^ bit_cnt_inc[0];
          end
        end
        ST_DATA: begin
          if (bit_cnt == DATA_LAST) begin
            if (GAP_BITS > 0) begin
              state_nxt    = ST_GAP;
              bit_cnt_nxt  = '0;
              line_bit_nxt = 1'b0;
            end else begin
              frame_end = 1'b1;
            end
          end else begin
            bit_cnt_nxt  = bit_cnt_inc;
            line_bit_nxt = shift_reg[0];
            shift_nxt    = shift_reg >> 1;
          end
        end
        ST_GAP: begin
          if (bit_cnt == GAP_LAST) begin
            frame_end = 1'b1;
          end else begin
            bit_cnt_nxt  = bit_cnt_inc;
            line_bit_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase

      if (frame_end) begin
        state_nxt    = ST_IDLE;
        bit_cnt_nxt  = '0;
        line_bit_nxt = 1'b0;
        rr_nxt       = ~GRANT_ID;
        ptr_now      = ~GRANT_ID;
        start_ok     = 1'b1;
      end

      // Both requesting: pointer decides. One requesting: it wins.
      if (start_ok && (REQ0_VALID || REQ1_VALID)) begin
        pick         = (REQ0_VALID && REQ1_VALID) ? ptr_now : REQ1_VALID;
        grant_nxt    = pick;
        ready0       = ~pick;
        ready1       = pick;
        shift_nxt    = pick ? REQ1_DATA : REQ0_DATA;
        line_bit_nxt = PRE_START_BIT;
        state_nxt    = ST_PRE;
        bit_cnt_nxt  = '0;
      end
    end
  end

  assign REQ0_READY  = ready0;
  assign REQ1_READY  = ready1;
  assign FRAME_DONE  = frame_end;
  assign LINE_ACTIVE = (state != ST_IDLE);

endmodule
